// File: rtl/gigatron_pkg.sv
// Shared constants for the Gigatron input path: button/OUT bit positions and
// the switch-to-controller-byte mapping.
package gigatron_pkg;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_START  = 4;
  localparam int BTN_SELECT = 5;
  localparam int BTN_B      = 6;
  localparam int BTN_A      = 7;

  localparam int OUT_HSYNC  = 6;
  localparam int OUT_VSYNC  = 7;

  localparam int NUM_SW     = 4;

  localparam logic [7:0] BUTTONS_RELEASED = 8'hFF;

  // Accepted switches are active-high; the controller byte is active-low.
  // Start is synthesised from Up+Down held together.
  function automatic logic [7:0] map_buttons(input logic [NUM_SW-1:0] acc);
    logic [7:0] b;
    b              = BUTTONS_RELEASED;
    b[BTN_RIGHT]   = ~acc[0];
    b[BTN_LEFT]    = ~acc[1];
    b[BTN_DOWN]    = ~acc[2];
    b[BTN_UP]      = ~acc[3];
    b[BTN_START]   = ~(acc[2] & acc[3]);
    return b;
  endfunction

endpackage

// File: rtl/gigatron_in_port_switch_debouncer.sv
// One board switch: two-flop synchronizer plus, when GIGATRON_IN_DEBOUNCE_EN
// is defined, a stable-input counter gating changes to the accepted value.
module switch_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  output logic accepted
);

  logic [1:0] sync_q;

  always_ff @(posedge clock) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], sw_raw};
  end

`ifdef GIGATRON_IN_DEBOUNCE_EN
  localparam logic [15:0] LAST = (DEBOUNCE_CYCLES == 16'd0) ? 16'd0 : DEBOUNCE_CYCLES - 16'd1;

  logic [15:0] cnt;
  logic        acc_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt   <= 16'd0;
      acc_q <= 1'b0;
    end else if (sync_q[1] == acc_q) begin
      cnt <= 16'd0;
    end else if (cnt == LAST) begin
      acc_q <= sync_q[1];
      cnt   <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign accepted = acc_q;
`else
  assign accepted = sync_q[1];
`endif

endmodule

// File: rtl/gigatron_in_port.sv
// Gigatron IN-bus source: debounced switches -> controller byte, modelled
// serial link clocked by the CPU's own OUT-register sync bits.
// Build option: GIGATRON_IN_DEBOUNCE_EN enables the debounce counters.
module gigatron_in_port
  import gigatron_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       out_strobe,
  input  logic [7:0] out_data,
  output logic [7:0] in_data,
  output logic [7:0] buttons,
  output logic [7:0] frame_count
);

  logic [NUM_SW-1:0] acc;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock   (clock),
      .reset   (reset),
      .sw_raw  (sw[i]),
      .accepted(acc[i])
    );
  end

  logic [7:0] buttons_q;

  always_ff @(posedge clock) begin
    if (!reset) buttons_q <= BUTTONS_RELEASED;
    else        buttons_q <= map_buttons(acc);
  end

  assign buttons = buttons_q;

  // {vsync, hsync}; sync_prev trails sync_reg by one cycle so each
  // strobe-induced transition yields a single-cycle edge pulse.
  logic [1:0] sync_reg, sync_prev;
  logic       hsync_rise, vsync_fall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_reg  <= 2'b11;
      sync_prev <= 2'b11;
    end else begin
      if (out_strobe) sync_reg <= {out_data[OUT_VSYNC], out_data[OUT_HSYNC]};
      sync_prev <= sync_reg;
    end
  end

  assign hsync_rise = ~sync_prev[0] &  sync_reg[0];
  assign vsync_fall =  sync_prev[1] & ~sync_reg[1];

  logic [7:0] ctrl_sr, in_sr, frame_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ctrl_sr <= BUTTONS_RELEASED;
      in_sr   <= 8'hFF;
      frame_q <= 8'h00;
    end else begin
      // Load takes priority over shift while vsync is low.
      if (!sync_reg[1])    ctrl_sr <= buttons_q;
      else if (hsync_rise) ctrl_sr <= {ctrl_sr[6:0], 1'b1};
      if (hsync_rise)      in_sr   <= {in_sr[6:0], ctrl_sr[7]};
      if (vsync_fall)      frame_q <= frame_q + 8'd1;
    end
  end

  assign in_data     = in_sr;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_gigatron_in_port.sv
// Scenario bench for gigatron_in_port: a transaction-level model pushes the
// expected in_data/frame_count per OUT strobe, popped once the edge has acted.
module tb_gigatron_in_port;

  localparam logic [15:0] DB = 16'd16;
`ifdef GIGATRON_IN_DEBOUNCE_EN
  localparam int LAT = int'(DB) + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       out_strobe = 1'b0;
  logic [7:0] out_data = 8'hFF;
  logic [7:0] in_data, buttons, frame_count;

  gigatron_in_port #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock      (clock),
    .reset      (reset),
    .sw         (sw),
    .out_strobe (out_strobe),
    .out_data   (out_data),
    .in_data    (in_data),
    .buttons    (buttons),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] in;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] m_in, m_ctrl, m_btn, m_fc;
  logic [1:0] m_sync;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_in   = 8'hFF;
    m_ctrl = 8'hFF;
    m_sync = 2'b11;
    m_fc   = 8'h00;
  endtask

  // Drive one OUT write, advance the model, push the expected outcome.
  task automatic send_out(input logic v, input logic h);
    logic [1:0] prev;
    logic       hr;
    prev   = m_sync;
    m_sync = {v, h};
    if (prev[1] && !v) m_fc = m_fc + 8'd1;
    hr = !prev[0] && h;
    if (hr) begin
      m_in   = {m_in[6:0], m_ctrl[7]};
      m_ctrl = v ? {m_ctrl[6:0], 1'b1} : m_btn;
    end else if (!v) begin
      m_ctrl = m_btn;
    end
    sb.push_back('{m_in, m_fc});
    out_strobe = 1'b1;
    out_data   = {v, h, 6'h15};
    tick(1);
    out_strobe = 1'b0;
    out_data   = {~v, ~h, 6'h2A};
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sw    = 4'h0;
    tick(3);
    n_checks++;
    if (in_data !== 8'hFF || buttons !== 8'hFF || frame_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: in=%h btn=%h fc=%h want FF FF 00", in_data, buttons, frame_count);
    end
    reset = 1'b1;
    model_reset();
    m_btn = 8'hFF;
    tick(1);
  endtask

  // vsync low, vsync high, then `rises` hsync rising edges.
  task automatic test_frame(input string nm, input int rises,
                            input logic [7:0] exp_in, input logic [7:0] exp_fc);
    exp_t e;
    for (int s = 0; s < 2 + 2 * rises; s++) begin
      if (s == 0)      send_out(1'b0, 1'b1);
      else if (s == 1) send_out(1'b1, 1'b1);
      else             send_out(1'b1, s[0]);
      e = sb.pop_front();
      n_checks++;
      if (in_data !== e.in || frame_count !== e.fc) begin
        n_fail++;
        $display("FAIL %s strobe %0d: in=%h fc=%h want %h %h", nm, s, in_data, frame_count, e.in, e.fc);
      end
    end
    n_checks++;
    if (in_data !== exp_in || frame_count !== exp_fc) begin
      n_fail++;
      $display("FAIL %s final: in=%h fc=%h want %h %h", nm, in_data, frame_count, exp_in, exp_fc);
    end
  endtask

  // Exact latency: old value one cycle before, new value on the cycle.
  task automatic test_debounce(input string nm, input logic [3:0] swv,
                               input logic [7:0] old_b, input logic [7:0] new_b);
    sw = swv;
    tick(LAT - 1);
    n_checks++;
    if (buttons !== old_b) begin
      n_fail++;
      $display("FAIL %s early: btn=%h want %h", nm, buttons, old_b);
    end
    tick(1);
    n_checks++;
    if (buttons !== new_b) begin
      n_fail++;
      $display("FAIL %s latency: btn=%h want %h", nm, buttons, new_b);
    end
    m_btn = new_b;
  endtask

  task automatic test_glitch();
    sw = 4'h2;
`ifdef GIGATRON_IN_DEBOUNCE_EN
    for (int c = 1; c <= int'(DB) + 4; c++) begin
      tick(1);
      if (c == int'(DB) - 2) sw = 4'h0;
      n_checks++;
      if (buttons !== 8'hFF) begin
        n_fail++;
        $display("FAIL glitch cycle %0d: btn=%h want FF", c, buttons);
      end
    end
`else
    tick(2);
    n_checks++;
    if (buttons !== 8'hFF) begin
      n_fail++;
      $display("FAIL glitch early: btn=%h want FF", buttons);
    end
    tick(1);
    n_checks++;
    if (buttons !== 8'hFD) begin
      n_fail++;
      $display("FAIL glitch pass: btn=%h want FD", buttons);
    end
    tick(int'(DB) - 5);
    sw = 4'h0;
    tick(LAT + 1);
    n_checks++;
    if (buttons !== 8'hFF) begin
      n_fail++;
      $display("FAIL glitch release: btn=%h want FF", buttons);
    end
`endif
  endtask

  task automatic test_wrap();
    exp_t e;
    sw    = 4'h0;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    model_reset();
    m_btn = 8'hFF;
    for (int i = 0; i < 256; i++) begin
      send_out(1'b0, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if (frame_count !== e.fc) begin
        n_fail++;
        $display("FAIL wrap fall %0d: fc=%h want %h", i, frame_count, e.fc);
      end
      send_out(1'b1, 1'b1);
      void'(sb.pop_front());
      if (i == 254) begin
        n_checks++;
        if (frame_count !== 8'hFF) begin
          n_fail++;
          $display("FAIL wrap top: fc=%h want FF", frame_count);
        end
      end
    end
    n_checks++;
    if (frame_count !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap zero: fc=%h want 00", frame_count);
    end
  endtask

  task automatic test_mid_reset();
    test_debounce("updown2", 4'hC, 8'hFF, 8'hE3);
    test_frame("pre_reset", 8, 8'hE3, 8'h01);
    test_frame("partial2", 3, 8'h1F, 8'h02);
    sw    = 4'h0;
    reset = 1'b0;
    tick(1);
    n_checks++;
    if (in_data !== 8'hFF || buttons !== 8'hFF || frame_count !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: in=%h btn=%h fc=%h want FF FF 00", in_data, buttons, frame_count);
    end
    reset = 1'b1;
    model_reset();
    m_btn = 8'hFF;
    tick(LAT + 1);
    test_frame("post_reset", 8, 8'hFF, 8'h01);
  endtask

  initial begin
    test_reset();
    test_frame("idle", 8, 8'hFF, 8'h01);
    test_debounce("right", 4'h1, 8'hFF, 8'hFE);
    test_frame("right", 8, 8'hFE, 8'h02);
    test_debounce("updown", 4'hC, 8'hFE, 8'hE3);
    test_frame("updown", 8, 8'hE3, 8'h03);
    test_debounce("release", 4'h0, 8'hE3, 8'hFF);
    test_glitch();
    test_frame("refill", 8, 8'hFF, 8'h04);
    test_debounce("right2", 4'h1, 8'hFF, 8'hFE);
    test_frame("partial", 3, 8'hFF, 8'h05);
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
